// File: rtl/spi_slave_mode0_if.sv
`timescale 1ns/1ps
// spi_slave_mode0_if
// Bundles the SPI pins and the parallel side of the mode-0 responder.
//   sclk, cs_n, mosi : SPI pins driven by the master (asynchronous to clk)
//   miso, miso_oe    : SPI return data and its output enable
//   tx_data, tx_load : next word to transmit / capture strobe
//   rx_data, rx_valid: last received word / update strobe
//   busy, frame_err  : frame active / frame ended on a partial word
interface spi_slave_mode0_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              frame_err;

  modport slave (
    input  sclk, cs_n, mosi, tx_data,
    output miso, miso_oe, tx_load, rx_data, rx_valid, busy, frame_err
  );

  modport master (
    output sclk, cs_n, mosi, tx_data,
    input  miso, miso_oe, tx_load, rx_data, rx_valid, busy, frame_err
  );
endinterface

// File: rtl/spi_slave_mode0.sv
`timescale 1ns/1ps
// spi_slave_mode0
// SPI mode-0 responder running on the system clock. sclk/mosi/cs_n are
// oversampled through SYNC_STAGES flops; edges are detected on the last
// synchronized value. Receives MSB-first on mosi, transmits MSB-first on miso.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : spi_slave_mode0_if.slave (SPI pins + parallel word interface)
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | not selected; miso/miso_oe low, waiting for cs_n fall
// S_ACTIVE | selected; sample mosi on sclk rise, shift miso on sclk fall
module spi_slave_mode0 #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  spi_slave_mode0_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sclk_d, r_cs_d;
  logic [SYNC_STAGES:0]   r_settle;
  logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_W-1:0]      r_tx_shift, w_tx_shift_nxt;
  logic [DATA_W-1:0]      r_rx_shift, w_rx_shift_nxt;
  logic [DATA_W-1:0]      r_rx_data, w_rx_data_nxt;
  logic                   r_rx_valid, w_rx_valid_nxt;
  logic                   r_tx_load, w_tx_load_nxt;
  logic                   r_frame_err, w_frame_err_nxt;

  logic w_sclk, w_mosi, w_cs, w_ready;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_settle    <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
      r_settle    <= {r_settle[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];

  // Edges are masked until the chains and delay flops hold real pin values.
  // Without this, a cs_n already low at reset release would look like a
  // falling edge against the reset value of 1 and start a bogus frame.
  assign w_ready     = r_settle[SYNC_STAGES];
  assign w_sclk_rise = w_ready &  w_sclk & ~r_sclk_d;
  assign w_sclk_fall = w_ready & ~w_sclk &  r_sclk_d;
  assign w_cs_fall   = w_ready & ~w_cs   &  r_cs_d;
  assign w_cs_rise   = w_ready &  w_cs   & ~r_cs_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_tx_shift  <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_tx_load   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_tx_load   <= w_tx_load_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_tx_shift_nxt  = r_tx_shift;
    w_rx_shift_nxt  = r_rx_shift;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_tx_load_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_tx_shift_nxt = bus.tx_data;
          w_tx_load_nxt  = 1'b1;
          w_bit_cnt_nxt  = '0;
          w_rx_shift_nxt = '0;
          w_state_nxt    = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // cs_n rise wins over an sclk edge landing in the same cycle.
        if (w_cs_rise) begin
          w_state_nxt     = S_IDLE;
          w_frame_err_nxt = (r_bit_cnt != '0);
          w_bit_cnt_nxt   = '0;
          w_rx_shift_nxt  = '0;
        end else if (w_sclk_rise) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_rx_data_nxt  = {r_rx_shift[DATA_W-2:0], w_mosi};
            w_rx_valid_nxt = 1'b1;
            w_bit_cnt_nxt  = '0;
            w_rx_shift_nxt = '0;
            w_tx_shift_nxt = bus.tx_data;
            w_tx_load_nxt  = 1'b1;
          end else begin
            w_rx_shift_nxt = {r_rx_shift[DATA_W-2:0], w_mosi};
            w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
          end
        end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
          // The fall right after a word boundary does not shift, so the
          // freshly loaded MSB is still on miso at the next rise.
          w_tx_shift_nxt = {r_tx_shift[DATA_W-2:0], 1'b0};
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.miso      = (r_state == S_ACTIVE) & r_tx_shift[DATA_W-1];
  assign bus.miso_oe   = (r_state == S_ACTIVE);
  assign bus.busy      = (r_state == S_ACTIVE);
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.tx_load   = r_tx_load;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_slave_mode0.sv
`timescale 1ns/1ps
// tb_spi_slave_mode0
// Directed bench: a behavioural SPI mode-0 master drives the responder and
// captures miso on each sclk rise; a monitor logs every rx_valid word and
// counts tx_load / frame_err cycles.
module tb_spi_slave_mode0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_mode0_if #(.DATA_W(8)) bus ();

  spi_slave_mode0 #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int         n_rx   = 0;
  int         n_txl  = 0;
  int         n_ferr = 0;
  logic [7:0] rx_log [0:63];

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_log[n_rx % 64] <= bus.rx_data;
      n_rx <= n_rx + 1;
    end
    if (bus.tx_load)   n_txl  <= n_txl + 1;
    if (bus.frame_err) n_ferr <= n_ferr + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, input int lo, input int hi,
                           output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = tx[7-i];
      repeat (lo) @(negedge clk);
      bus.sclk = 1'b1;
      rx = {rx[6:0], bus.miso};
      repeat (hi) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (3) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  logic [7:0] rd, rd0, rd1, rd2;
  int b_rx, b_txl, b_ferr;
  logic [7:0] rand_tab [0:15] = '{8'h3A, 8'hC5, 8'h00, 8'hFF, 8'h96, 8'h69, 8'h0F, 8'hF0,
                                  8'h81, 8'h7E, 8'h55, 8'hAA, 8'h12, 8'hED, 8'h48, 8'hB7};

  initial begin
    bus.sclk    = 1'b0;
    bus.cs_n    = 1'b1;
    bus.mosi    = 1'b0;
    bus.tx_data = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_miso_oe",   {31'd0, bus.miso_oe},   32'd0);
    check("rst_miso",      {31'd0, bus.miso},      32'd0);
    check("rst_rx_data",   {24'd0, bus.rx_data},   32'd0);
    check("rst_rx_valid",  {31'd0, bus.rx_valid},  32'd0);
    check("rst_tx_load",   {31'd0, bus.tx_load},   32'd0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // single byte: tx A5, master sends 3C
    bus.tx_data = 8'hA5;
    b_rx = n_rx; b_txl = n_txl;
    cs_low();
    check("sb_busy",    {31'd0, bus.busy},    32'd1);
    check("sb_miso_oe", {31'd0, bus.miso_oe}, 32'd1);
    check("sb_msb",     {31'd0, bus.miso},    32'd1);
    xfer_bits(8'h3C, 8, 4, 4, rd);
    cs_high();
    check("sb_master_rd", {24'd0, rd},             32'hA5);
    check("sb_rx_count",  n_rx - b_rx,             32'd1);
    check("sb_rx_log",    {24'd0, rx_log[b_rx % 64]}, 32'h3C);
    check("sb_rx_data",   {24'd0, bus.rx_data},    32'h3C);
    check("sb_tx_loads",  n_txl - b_txl,           32'd2);
    check("sb_idle_busy", {31'd0, bus.busy},       32'd0);

    // back-to-back: 01,80,FF while tx_data advances 11 -> 22 -> 33
    bus.tx_data = 8'h11;
    b_rx = n_rx; b_txl = n_txl;
    fork
      begin
        cs_low();
        xfer_bits(8'h01, 8, 4, 4, rd0);
        xfer_bits(8'h80, 8, 4, 4, rd1);
        xfer_bits(8'hFF, 8, 4, 4, rd2);
        cs_high();
      end
      begin
        for (int k = 0; k < 2; k++) begin
          int t;
          t = 0;
          do begin
            @(negedge clk);
            t++;
          end while (!bus.tx_load && t < 500);
          check("b2b_tx_load_seen", {31'd0, bus.tx_load}, 32'd1);
          bus.tx_data = (k == 0) ? 8'h22 : 8'h33;
          @(negedge clk);
        end
      end
    join
    check("b2b_rd0",      {24'd0, rd0}, 32'h11);
    check("b2b_rd1",      {24'd0, rd1}, 32'h22);
    check("b2b_rd2",      {24'd0, rd2}, 32'h33);
    check("b2b_rx_count", n_rx - b_rx, 32'd3);
    check("b2b_rx0", {24'd0, rx_log[(b_rx + 0) % 64]}, 32'h01);
    check("b2b_rx1", {24'd0, rx_log[(b_rx + 1) % 64]}, 32'h80);
    check("b2b_rx2", {24'd0, rx_log[(b_rx + 2) % 64]}, 32'hFF);
    check("b2b_tx_loads", n_txl - b_txl, 32'd4);

    // abort after 5 bits
    bus.tx_data = 8'h5E;
    b_rx = n_rx; b_ferr = n_ferr;
    cs_low();
    xfer_bits(8'hC7, 5, 4, 4, rd);
    cs_high();
    check("ab_frame_err", n_ferr - b_ferr,          32'd1);
    check("ab_rx_count",  n_rx - b_rx,              32'd0);
    check("ab_rx_data",   {24'd0, bus.rx_data},     32'hFF);
    check("ab_busy",      {31'd0, bus.busy},        32'd0);
    check("ab_miso_oe",   {31'd0, bus.miso_oe},     32'd0);
    check("ab_miso",      {31'd0, bus.miso},        32'd0);
    check("ab_partial_rd", {24'd0, rd},             32'h0B);

    // loopback-style exchange: master 5A, responder C3
    bus.tx_data = 8'hC3;
    b_rx = n_rx; b_ferr = n_ferr;
    cs_low();
    xfer_bits(8'h5A, 8, 4, 4, rd);
    cs_high();
    check("lb_master_rd", {24'd0, rd},          32'hC3);
    check("lb_rx_data",   {24'd0, bus.rx_data}, 32'h5A);
    check("lb_rx_count",  n_rx - b_rx,          32'd1);
    check("lb_no_ferr",   n_ferr - b_ferr,      32'd0);

    // reset mid-frame, released with cs_n still low
    bus.tx_data = 8'h99;
    cs_low();
    xfer_bits(8'hE0, 3, 4, 4, rd);
    rst_n = 1'b0;
    #1;
    check("rm_busy",      {31'd0, bus.busy},    32'd0);
    check("rm_miso_oe",   {31'd0, bus.miso_oe}, 32'd0);
    check("rm_rx_data",   {24'd0, bus.rx_data}, 32'h00);
    check("rm_tx_load",   {31'd0, bus.tx_load}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b_rx = n_rx; b_txl = n_txl; b_ferr = n_ferr;
    repeat (2) @(negedge clk);
    xfer_bits(8'hFF, 5, 4, 4, rd);
    repeat (4) @(negedge clk);
    check("rm_stay_idle", {31'd0, bus.busy}, 32'd0);
    cs_high();
    check("rm_no_rx",   n_rx - b_rx,     32'd0);
    check("rm_no_txl",  n_txl - b_txl,   32'd0);
    check("rm_no_ferr", n_ferr - b_ferr, 32'd0);
    cs_low();
    xfer_bits(8'h77, 8, 4, 4, rd);
    cs_high();
    check("rm_next_rx",   {24'd0, bus.rx_data}, 32'h77);
    check("rm_next_rd",   {24'd0, rd},          32'h99);
    check("rm_next_cnt",  n_rx - b_rx,          32'd1);

    // edge-rate limit: 3/5 then 5/3 duty, 8 bytes each
    bus.tx_data = 8'h6D;
    b_rx = n_rx;
    for (int f = 0; f < 2; f++) begin
      cs_low();
      for (int j = 0; j < 8; j++) begin
        if (f == 0) xfer_bits(rand_tab[f*8 + j], 8, 3, 5, rd);
        else        xfer_bits(rand_tab[f*8 + j], 8, 5, 3, rd);
        check($sformatf("er_rd_%0d", f*8 + j), {24'd0, rd}, 32'h6D);
      end
      cs_high();
    end
    check("er_rx_count", n_rx - b_rx, 32'd16);
    for (int j = 0; j < 16; j++)
      check($sformatf("er_rx_%0d", j), {24'd0, rx_log[(b_rx + j) % 64]}, {24'd0, rand_tab[j]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
